// File: rtl/iq_freq_discriminator.sv
// Differential FM discriminator for the O-QPSK/MSK receive path.
// d[n] = I[n-1]*Q[n] - Q[n-1]*I[n] is integrated over OSR samples per chip.
// A chip decision is 1 when the integrated sum is >= 0.
module iq_freq_discriminator #(
  parameter  int DW  = 5,
  parameter  int OSR = 4,
  localparam int PW  = 2*DW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] data_in_I,
  input  logic [DW-1:0] data_in_Q,
  input  logic          align,
  output logic          disc_valid,
  output logic [PW-1:0] disc_out,
  output logic          chip_valid,
  output logic          chip_out
);

  localparam int PRW = 2*DW;
  localparam int AW  = PW + $clog2(OSR);
  localparam int CW  = (OSR > 1) ? $clog2(OSR) : 1;

  typedef enum logic {EMPTY, RUN} state_e;

  state_e                 state_q, state_d;
  logic signed [DW-1:0]   prev_i_q, prev_i_d, prev_q_q, prev_q_d;
  logic signed [DW-1:0]   cur_i_q, cur_i_d, cur_q_q, cur_q_d;
  logic                   s1_valid_q, s1_valid_d;
  logic signed [PRW-1:0]  p1_q, p1_d, p2_q, p2_d;
  logic                   s2_valid_q, s2_valid_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   chip_out_q, chip_out_d;
  logic                   chip_valid_q, chip_valid_d;
  logic signed [PW-1:0]   disc_w;
  logic signed [AW-1:0]   acc_sum;

  // History FSM and sample capture: the first sample only primes the history.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no latch is inferred.
    state_d    = state_q;
    prev_i_d   = prev_i_q;
    prev_q_d   = prev_q_q;
    cur_i_d    = cur_i_q;
    cur_q_d    = cur_q_q;
    s1_valid_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        EMPTY: begin
          prev_i_d = data_in_I;
          prev_q_d = data_in_Q;
          cur_i_d  = data_in_I;
          cur_q_d  = data_in_Q;
          state_d  = RUN;
        end
        RUN: begin
          prev_i_d   = cur_i_q;
          prev_q_d   = cur_q_q;
          cur_i_d    = data_in_I;
          cur_q_d    = data_in_Q;
          s1_valid_d = 1'b1;
        end
      endcase
    end
  end

  // Cross-product stage; product registers hold between samples so disc_out holds.
  always_comb begin
    p1_d       = p1_q;
    p2_d       = p2_q;
    s2_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      p1_d = PRW'(prev_i_q) * PRW'(cur_q_q);
      p2_d = PRW'(prev_q_q) * PRW'(cur_i_q);
    end
  end

  assign disc_w  = PW'(p1_q) - PW'(p2_q);
  assign acc_sum = acc_q + AW'(disc_w);

  // Chip integrator: align wins over a coincident discriminator sample.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    chip_out_d   = chip_out_q;
    chip_valid_d = 1'b0;
    if (align) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (s2_valid_q) begin
      if (cnt_q == CW'(OSR - 1)) begin
        chip_out_d   = ~acc_sum[AW-1];
        chip_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register; synchronous reset clears history, pipeline and integrator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      prev_i_q     <= '0;
      prev_q_q     <= '0;
      cur_i_q      <= '0;
      cur_q_q      <= '0;
      s1_valid_q   <= 1'b0;
      p1_q         <= '0;
      p2_q         <= '0;
      s2_valid_q   <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      chip_out_q   <= 1'b0;
      chip_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the previous cycle's values.
      state_q      <= state_d;
      prev_i_q     <= prev_i_d;
      prev_q_q     <= prev_q_d;
      cur_i_q      <= cur_i_d;
      cur_q_q      <= cur_q_d;
      s1_valid_q   <= s1_valid_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      s2_valid_q   <= s2_valid_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      chip_out_q   <= chip_out_d;
      chip_valid_q <= chip_valid_d;
    end
  end

  assign disc_valid = s2_valid_q;
  assign disc_out   = disc_w;
  assign chip_valid = chip_valid_q;
  assign chip_out   = chip_out_q;

endmodule

// File: tb/tb_iq_freq_discriminator.sv
// Self-checking bench for iq_freq_discriminator (DW=5, OSR=4).
module tb_iq_freq_discriminator;

  localparam int DW  = 5;
  localparam int OSR = 4;
  localparam int PW  = 2*DW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          align = 1'b0;
  logic [DW-1:0] data_in_I = '0;
  logic [DW-1:0] data_in_Q = '0;
  logic          disc_valid;
  logic [PW-1:0] disc_out;
  logic          chip_valid;
  logic          chip_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int disc_obs[$];
  int disc_cyc[$];
  int chip_obs[$];
  int chip_cyc[$];
  int stim_i[$];
  int stim_q[$];
  int exp_d[$];
  int exp_chip[$];

  iq_freq_discriminator #(.DW(DW), .OSR(OSR)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .data_in_I  (data_in_I),
    .data_in_Q  (data_in_Q),
    .align      (align),
    .disc_valid (disc_valid),
    .disc_out   (disc_out),
    .chip_valid (chip_valid),
    .chip_out   (chip_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every strobe with the cycle it was seen in.
  always @(negedge clk) begin
    if (disc_valid) begin
      disc_obs.push_back(int'($signed(disc_out)));
      disc_cyc.push_back(cyc);
    end
    if (chip_valid) begin
      chip_obs.push_back(int'(chip_out));
      chip_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit v, input int i, input int q, input bit al);
    @(negedge clk);
    in_valid  = v;
    data_in_I = DW'(i);
    data_in_Q = DW'(q);
    align     = al;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; align = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    disc_obs.delete(); disc_cyc.delete();
    chip_obs.delete(); chip_cyc.delete();
    stim_i.delete(); stim_q.delete();
  endtask

  task automatic add(input int i, input int q);
    stim_i.push_back(i);
    stim_q.push_back(q);
  endtask

  // Reference model: d from consecutive samples, chip = sign of each OSR-sized group sum.
  task automatic build_expect();
    int sum;
    exp_d.delete();
    exp_chip.delete();
    for (int k = 1; k < stim_i.size(); k++)
      exp_d.push_back(stim_i[k-1]*stim_q[k] - stim_q[k-1]*stim_i[k]);
    for (int g = 0; (g + 1) * OSR <= exp_d.size(); g++) begin
      sum = 0;
      for (int j = 0; j < OSR; j++) sum += exp_d[g*OSR + j];
      exp_chip.push_back(sum >= 0 ? 1 : 0);
    end
  endtask

  task automatic run_stim(input bit cadence);
    int slot = 0;
    foreach (stim_i[k]) begin
      while (cadence && (slot % 5 == 4)) begin
        drive(1'b0, 0, 0, 1'b0);
        slot++;
      end
      drive(1'b1, stim_i[k], stim_q[k], 1'b0);
      slot++;
    end
    idle(8);
  endtask

  task automatic compare_model(input string tag);
    build_expect();
    n_checks++;
    if (disc_obs.size() !== exp_d.size()) begin
      n_fail++;
      $display("FAIL %s disc count: got %0d expected %0d", tag, disc_obs.size(), exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && k < disc_obs.size(); k++) begin
      n_checks++;
      if (disc_obs[k] !== exp_d[k]) begin
        n_fail++;
        $display("FAIL %s d[%0d]: got %0d expected %0d", tag, k, disc_obs[k], exp_d[k]);
      end
    end
    n_checks++;
    if (chip_obs.size() !== exp_chip.size()) begin
      n_fail++;
      $display("FAIL %s chip count: got %0d expected %0d", tag, chip_obs.size(), exp_chip.size());
    end
    for (int k = 0; k < exp_chip.size() && k < chip_obs.size(); k++) begin
      n_checks++;
      if (chip_obs[k] !== exp_chip[k]) begin
        n_fail++;
        $display("FAIL %s chip[%0d]: got %0d expected %0d", tag, k, chip_obs[k], exp_chip[k]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({disc_valid, chip_valid, chip_out} !== 3'b000 || disc_out !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got dv=%b cv=%b co=%b do=%0d expected all 0",
               disc_valid, chip_valid, chip_out, disc_out);
    end
  endtask

  task automatic test_first_pair();
    int c2;
    do_reset();
    add(5, 0); add(0, 5);
    drive(1'b1, 5, 0, 1'b0);
    drive(1'b1, 0, 5, 1'b0);
    c2 = cyc;
    idle(6);
    n_checks++;
    if (disc_obs.size() !== 1) begin
      n_fail++;
      $display("FAIL first_pair count: got %0d expected 1", disc_obs.size());
    end else begin
      n_checks++;
      if (disc_obs[0] !== 25) begin
        n_fail++;
        $display("FAIL first_pair value: got %0d expected 25", disc_obs[0]);
      end
      n_checks++;
      if (disc_cyc[0] !== c2 + 2) begin
        n_fail++;
        $display("FAIL first_pair latency: got cycle %0d expected %0d", disc_cyc[0], c2 + 2);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    add(-16, -16); add(15, -16); add(-16, -16); add(-16, 15);
    run_stim(1'b0);
    compare_model("extremes");
    n_checks++;
    if (disc_obs.size() < 3 || disc_obs[0] !== 496 || disc_obs[2] !== -496) begin
      n_fail++;
      $display("FAIL extremes range: got %p expected 496 first and -496 third", disc_obs);
    end
  endtask

  task automatic test_chip_decision();
    // Each list yields four d values: +25 x4, -25 x4, alternating +25/-25.
    int li[3][5] = '{'{5, 0, -5, 0, 5}, '{5, 0, -5, 0, 5}, '{5, 0, 5, 0, 5}};
    int lq[3][5] = '{'{0, 5, 0, -5, 0}, '{0, -5, 0, 5, 0}, '{0, 5, 0, 5, 0}};
    int want[3]  = '{1, 0, 1};
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int k = 0; k < 5; k++) add(li[s][k], lq[s][k]);
      run_stim(1'b0);
      compare_model($sformatf("chip%0d", s));
      n_checks++;
      if (chip_obs.size() !== 1 || chip_obs[0] !== want[s] || disc_cyc.size() != 4 ||
          chip_cyc[0] !== disc_cyc[3] + 1) begin
        n_fail++;
        $display("FAIL chip%0d strobe: got %p at %p expected %0d one cycle after last d %p",
                 s, chip_obs, chip_cyc, want[s], disc_cyc);
      end
    end
  endtask

  task automatic test_cadence();
    do_reset();
    for (int k = 0; k < 21; k++)
      add(int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16);
    run_stim(1'b1);
    compare_model("cadence");
  endtask

  task automatic test_align();
    do_reset();
    add(5, 0); add(0, 5); add(2, 0);
    foreach (stim_i[k]) drive(1'b1, stim_i[k], stim_q[k], 1'b0);
    idle(4);
    drive(1'b0, 0, 0, 1'b1);
    idle(2);
    drive(1'b1, 0, -5, 1'b0);
    drive(1'b1, -2, 0, 1'b0);
    drive(1'b1, 0, 5, 1'b0);
    drive(1'b1, 2, 0, 1'b0);
    idle(8);
    n_checks++;
    if (disc_obs.size() !== 6 || chip_obs.size() !== 1 || chip_obs[0] !== 0 ||
        chip_cyc[0] !== disc_cyc[5] + 1) begin
      n_fail++;
      $display("FAIL align_idle: got chips %p at %p expected one 0 after d %p",
               chip_obs, chip_cyc, disc_cyc);
    end
    for (int k = 2; k < 6 && k < disc_obs.size(); k++) begin
      n_checks++;
      if (disc_obs[k] !== -10) begin
        n_fail++;
        $display("FAIL align_idle d[%0d]: got %0d expected -10", k, disc_obs[k]);
      end
    end

    // Align lands on the cycle the first d is valid, so that d is dropped.
    do_reset();
    add(2, 0); add(0, -5); add(-2, 0); add(0, 5); add(2, 0); add(0, -5);
    foreach (stim_i[k]) drive(1'b1, stim_i[k], stim_q[k], k == 3);
    idle(8);
    n_checks++;
    if (disc_obs.size() !== 5 || chip_obs.size() !== 1 || chip_obs[0] !== 0 ||
        chip_cyc[0] !== disc_cyc[4] + 1) begin
      n_fail++;
      $display("FAIL align_coincident: got chips %p at %p expected one 0 after d %p",
               chip_obs, chip_cyc, disc_cyc);
    end
  endtask

  task automatic test_reset_mid_chip();
    do_reset();
    add(5, 0); add(0, 5); add(-5, 0); add(0, -5); add(5, 0); add(0, 5); add(-5, 0);
    run_stim(1'b0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; data_in_I = 5'd3; data_in_Q = 5'd3;
    @(negedge clk);
    n_checks++;
    if ({disc_valid, chip_valid, chip_out} !== 3'b000 || disc_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got dv=%b cv=%b co=%b do=%0d expected all 0",
               disc_valid, chip_valid, chip_out, disc_out);
    end
    reset = 1'b0; in_valid = 1'b0;
    disc_obs.delete(); disc_cyc.delete(); chip_obs.delete(); chip_cyc.delete();
    stim_i.delete(); stim_q.delete();
    add(7, 3);
    drive(1'b1, 7, 3, 1'b0);
    idle(6);
    n_checks++;
    if (disc_obs.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_mid first sample: got %0d disc strobes expected 0", disc_obs.size());
    end
    add(-4, 6); add(9, -2); add(-11, -7); add(3, 12);
    for (int k = 1; k < 5; k++) drive(1'b1, stim_i[k], stim_q[k], 1'b0);
    idle(8);
    compare_model("reset_mid");
    n_checks++;
    if (chip_cyc.size() !== 1 || disc_cyc.size() != 4 || chip_cyc[0] !== disc_cyc[3] + 1) begin
      n_fail++;
      $display("FAIL reset_mid chip timing: got %p expected one strobe after d %p",
               chip_cyc, disc_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_extremes();
    test_chip_decision();
    test_cadence();
    test_align();
    test_reset_mid_chip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
